uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one tx_fsm UART transmitter among N_REQ byte producers.
- Arbitrates pending requests and drives the transmitter's one-cycle start pulse and data_in byte.
- Times each frame internally, because tx_fsm exposes no busy/done signal, and sequences back-to-back frames.
- Sits between producer logic (command/status/debug sources) and tx_fsm, on the same clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 10, clocks per UART bit; must equal the tx_fsm instance parameter.
- FRAME_BITS, 10, bits per frame (start + 8 data + stop).
- GUARD_CYCLES, 0, extra idle clocks after each frame before the next grant.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request level; held until its ack.
- req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
- ack  out  N_REQ  one-cycle pulse when requester i's byte is captured.
- tx_start  out  1  to tx_fsm start; one-cycle pulse.
- tx_data  out  8  to tx_fsm data_in; stable from the start pulse to frame end.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset, sampled on a clk edge with RST=1:
  - state=IDLE, ack=0, tx_start=0, tx_data=8'h00, busy=0, grant_id=0.
  - Pointer ptr=0, meaning requester 0 has highest priority first.
  - Frame counter cleared.
- States: IDLE, SEND, GUARD.
- IDLE:
  - On an edge with req!=0, select the winner: the first set bit searching ptr, ptr+1, ... modulo N_REQ.
  - Same edge registers: tx_data<=req_data[winner], grant_id<=winner, ack[winner]<=1, tx_start<=1, cnt<=0, state<=SEND.
  - Latency: req seen at edge k gives tx_start/ack high during cycle k+1.
  - With req=0 the block stays in IDLE and outputs hold.
- SEND:
  - tx_start and ack are cleared on the first edge in SEND, so each is exactly one cycle wide.
  - cnt increments every edge.
  - When cnt==FRAME_BITS*CLKS_PER_BIT-1: go to GUARD if GUARD_CYCLES>0, else IDLE.
  - SEND therefore lasts exactly FRAME_BITS*CLKS_PER_BIT cycles (100 at defaults), measured from the tx_start cycle.
  - On exit, ptr<=(grant_id+1) mod N_REQ.
- GUARD: count GUARD_CYCLES edges, then go to IDLE.
- Request changes while busy: ignored; they are arbitrated on the first IDLE edge after busy falls.
- Back-to-back: with requests pending, IDLE lasts exactly one cycle between frames.
  - Start pulses are spaced FRAME_BITS*CLKS_PER_BIT+GUARD_CYCLES+1 cycles apart.
- Withdrawn request (req dropped before ack): no transfer, no ack.
- Requester with a single pending req: served every time; the pointer wrap must not starve it.
- Simultaneous requests: strict round-robin. Each requester is served at most once per N_REQ grants while the others are pending.
- tx_data changes only on a grant edge.
- Reset mid-frame: the scheduler returns to IDLE at once. tx_fsm is expected to share RST (inverted to RSTn) so both sides realign.
- Counter width: $clog2(FRAME_BITS*CLKS_PER_BIT+GUARD_CYCLES+1). It never wraps.
- Invalid widths or parameters: none are handled at runtime. N_REQ<2 or CLKS_PER_BIT<1 is a static assertion failure.

Decomposition:
- Package uart_pkg:
  - typedef state_t enum {IDLE, SEND, GUARD}.
  - Localparam FRAME_BITS_DEFAULT=10.
  - Function frame_cycles(clks_per_bit, frame_bits).
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs: req, ptr.
  - Outputs: combinational one-hot grant, its index, and valid.
- Scheduler top: FSM, counter, and registers.

Test Plan:
1. RST=1 for 3 cycles, then req=4'b0001, data0=8'h55 -> tx_start and ack[0] high exactly 1 cycle, one cycle after req seen. tx_data=8'h55. busy high 100 cycles. grant_id=0.
2. req=4'b1111 held continuously, data i=8'hA0+i -> grant order 0,1,2,3,0. Start pulses exactly 101 cycles apart. Each ack one cycle.
3. Only requester 2 requesting, re-raised after every ack -> served every frame; grant_id always 2. No idle gap beyond one cycle.
4. During SEND, req=4'b0010 is raised then dropped at cycle 50 -> no ack[1], no second frame, busy falls after 100 cycles.
5. RST asserted at cycle 40 of a frame -> next edge busy=0, tx_start=0, ptr=0. Requests 0 and 3 pending after reset -> requester 0 granted first.
6. GUARD_CYCLES=5 with continuous req=4'b0011 -> start spacing 106 cycles. busy high throughout GUARD.
7. Co-simulate with tx_fsm #(10) in all scenarios -> TX line shows 8'h55 framed correctly, with no overlapping frames.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GUARD} state_t;

    localparam int FRAME_BITS_DEFAULT = 10;

    function automatic int frame_cycles(input int clks_per_bit, input int frame_bits);
        return clks_per_bit * frame_bits;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_cand;

    // Walk from farthest to nearest so the candidate closest to i_ptr is written last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_cand]) begin
                o_grant = N'(1) << w_cand;
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one tx_fsm among N_REQ byte producers; frames are timed locally because
// the transmitter reports no busy/done.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 10,
    parameter int FRAME_BITS   = FRAME_BITS_DEFAULT,
    parameter int GUARD_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int IW = $clog2(N_REQ);
    localparam int FC = frame_cycles(CLKS_PER_BIT, FRAME_BITS);
    localparam int CW = $clog2(FC + GUARD_CYCLES + 1);
    localparam logic [CW-1:0] SEND_LAST  = CW'(FC - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_ID    = IW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8 || CLKS_PER_BIT < 1) begin : g_bad_param
        $error("uart_tx_sched: N_REQ must be 2..8 and CLKS_PER_BIT >= 1");
    end

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_grant_id;
    logic [N_REQ-1:0] r_ack;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic            w_busy;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_valid;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_valid) w_next = SEND;
            SEND:  if (r_cnt == SEND_LAST) w_next = (GUARD_CYCLES > 0) ? GUARD : IDLE;
            GUARD: if (r_cnt == GUARD_LAST) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
    end

    // Start/ack are only ever set on the grant edge, so a default clear makes them one cycle wide.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_tx_data  <= req_data[{w_idx, 3'b000} +: 8];
                        r_grant_id <= w_idx;
                        r_ack      <= w_grant;
                        r_tx_start <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                SEND: begin
                    if (r_cnt == SEND_LAST) begin
                        r_cnt <= '0;
                        r_ptr <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GUARD: r_cnt <= r_cnt + 1'b1;
                default: r_cnt <= '0;
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign busy     = w_busy;
    assign grant_id = r_grant_id;

endmodule
